// File: rtl/iic_arb_pkg.sv
// Shared types and constants for the two-client IIC write-master arbiter.
package iic_arb_pkg;

  localparam int unsigned NUM_CLI = 2;

  // Register-select bytes that oled_ctrl sends as the address byte.
  localparam logic [7:0] OLED_CMD_REG = 8'h00;
  localparam logic [7:0] OLED_DAT_REG = 8'h40;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDrain
  } arb_state_e;

endpackage

// File: rtl/iic_bus_arbiter.sv
// Round-robin owner of the shared IIC write master: grants whole transactions,
// drains the master between owners and flags owners that hold the bus too long.
module iic_bus_arbiter
  import iic_arb_pkg::*;
#(
  parameter int unsigned CLK_FRE  = 50,
  parameter int unsigned HOLD_MAX = CLK_FRE * 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CLI-1:0]      cli_req,
  output logic [NUM_CLI-1:0]      cli_gnt,
  input  logic [NUM_CLI-1:0]      cli_send_en,
  input  logic [NUM_CLI-1:0][7:0] cli_send_addr,
  input  logic [NUM_CLI-1:0][7:0] cli_send_data,
  input  logic [NUM_CLI-1:0]      cli_brust_vaild,
  output logic [NUM_CLI-1:0]      cli_send_busy,
  output logic [NUM_CLI-1:0]      cli_brust_ready,
  output logic                    m_send_en,
  output logic                    m_brust_vaild,
  output logic [7:0]              m_send_addr,
  output logic [7:0]              m_send_data,
  input  logic                    m_send_busy,
  input  logic                    m_brust_ready,
  output logic                    err_hold,
  output logic                    owner
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        err_hold_q, err_hold_d;
  logic        other_req;

  assign other_req = cli_req[~owner_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      err_hold_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      err_hold_q   <= err_hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    err_hold_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|cli_req) begin
          // Contention goes to whoever did not own the bus last.
          owner_d    = (&cli_req) ? ~last_owner_q : cli_req[1];
          hold_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        // Counter saturates at HOLD_MAX, so the error fires at most once per grant.
        if (other_req && (hold_cnt_q != HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
        err_hold_d = (HOLD_MAX != 0) && (hold_cnt_d == HOLD_MAX) && (hold_cnt_q != HOLD_MAX);
        if (!cli_req[owner_q]) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!m_send_busy) begin
          last_owner_d = owner_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from registered state so an async reset drops them at once.
  always_comb begin
    cli_gnt         = '0;
    cli_send_busy   = '1;
    cli_brust_ready = '0;
    m_send_en       = 1'b0;
    m_brust_vaild   = 1'b0;
    m_send_addr     = '0;
    m_send_data     = '0;
    if (state_q == StGrant) begin
      cli_gnt[owner_q]         = 1'b1;
      cli_send_busy[owner_q]   = m_send_busy;
      cli_brust_ready[owner_q] = m_brust_ready;
      m_send_en                = cli_send_en[owner_q];
      m_brust_vaild            = cli_brust_vaild[owner_q];
      m_send_addr              = cli_send_addr[owner_q];
      m_send_data              = cli_send_data[owner_q];
    end
  end

  assign err_hold = err_hold_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_iic_bus_arbiter.sv
// Directed bench for iic_bus_arbiter with a short hold timeout.
module tb_iic_bus_arbiter;
  import iic_arb_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      cli_req;
  logic [1:0]      cli_gnt;
  logic [1:0]      cli_send_en;
  logic [1:0][7:0] cli_send_addr;
  logic [1:0][7:0] cli_send_data;
  logic [1:0]      cli_brust_vaild;
  logic [1:0]      cli_send_busy;
  logic [1:0]      cli_brust_ready;
  logic            m_send_en;
  logic            m_brust_vaild;
  logic [7:0]      m_send_addr;
  logic [7:0]      m_send_data;
  logic            m_send_busy;
  logic            m_brust_ready;
  logic            err_hold;
  logic            owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iic_bus_arbiter #(
    .CLK_FRE (50),
    .HOLD_MAX(10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cli_req        (cli_req),
    .cli_gnt        (cli_gnt),
    .cli_send_en    (cli_send_en),
    .cli_send_addr  (cli_send_addr),
    .cli_send_data  (cli_send_data),
    .cli_brust_vaild(cli_brust_vaild),
    .cli_send_busy  (cli_send_busy),
    .cli_brust_ready(cli_brust_ready),
    .m_send_en      (m_send_en),
    .m_brust_vaild  (m_brust_vaild),
    .m_send_addr    (m_send_addr),
    .m_send_data    (m_send_data),
    .m_send_busy    (m_send_busy),
    .m_brust_ready  (m_brust_ready),
    .err_hold       (err_hold),
    .owner          (owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    rst_n           = 1'b0;
    cli_req         = 2'b00;
    cli_send_en     = 2'b00;
    cli_send_addr   = '0;
    cli_send_data   = '0;
    cli_brust_vaild = 2'b00;
    m_send_busy     = 1'b0;
    m_brust_ready   = 1'b0;
    #12;
    chk("rst_gnt", cli_gnt, 2'b00);
    chk("rst_en", m_send_en, 1'b0);
    chk("rst_bv", m_brust_vaild, 1'b0);
    chk("rst_addr", m_send_addr, 8'h00);
    chk("rst_data", m_send_data, 8'h00);
    chk("rst_busy", cli_send_busy, 2'b11);
    chk("rst_rdy", cli_brust_ready, 2'b00);
    chk("rst_err", err_hold, 1'b0);
    chk("rst_owner", owner, 1'b0);
    rst_n = 1'b1;
    tick();

    // Request withdrawn before any edge sees it: no grant.
    cli_req = 2'b01;
    #2;
    cli_req = 2'b00;
    tick();
    chk("withdraw_gnt", cli_gnt, 2'b00);

    // Contention from reset: client 0 wins first.
    cli_req = 2'b11;
    cli_send_en = 2'b11;
    cli_send_addr[0] = OLED_CMD_REG;
    cli_send_data[0] = 8'hAE;
    cli_send_addr[1] = 8'h12;
    cli_send_data[1] = 8'h34;
    #1;
    chk("pre_gnt", cli_gnt, 2'b00);
    tick();
    chk("c0_gnt", cli_gnt, 2'b01);
    chk("c0_owner", owner, 1'b0);
    chk("c0_en", m_send_en, 1'b1);
    chk("c0_addr", m_send_addr, 8'h00);
    chk("c0_data", m_send_data, 8'hAE);
    chk("c0_busy_idle", cli_send_busy, 2'b10);
    m_send_busy = 1'b1;
    #1;
    chk("c0_busy_act", cli_send_busy, 2'b11);
    cli_send_en[0] = 1'b0;
    #1;
    chk("c0_en_mux", m_send_en, 1'b0);

    // Client 0 releases; DRAIN holds until the master goes idle.
    cli_send_en[0] = 1'b1;
    cli_req = 2'b10;
    tick();
    chk("drain_gnt", cli_gnt, 2'b00);
    chk("drain_en", m_send_en, 1'b0);
    chk("drain_busy", cli_send_busy, 2'b11);
    tick();
    chk("drain_wait", cli_gnt, 2'b00);
    m_send_busy = 1'b0;
    tick();
    chk("idle_gap", cli_gnt, 2'b00);
    tick();
    chk("c1_gnt", cli_gnt, 2'b10);
    chk("c1_owner", owner, 1'b1);
    chk("c1_addr", m_send_addr, 8'h12);
    chk("c1_data", m_send_data, 8'h34);
    chk("c1_busy", cli_send_busy, 2'b01);

    // Client 1 releases, client 0 takes the bus alone.
    cli_req = 2'b00;
    tick();
    tick();
    cli_req = 2'b01;
    tick();
    chk("rr_c0_gnt", cli_gnt, 2'b01);
    // Client 0 releases then re-requests while client 1 waits: client 1 wins.
    cli_req = 2'b10;
    tick();
    chk("rr_drain", cli_gnt, 2'b00);
    cli_req = 2'b11;
    tick();
    chk("rr_idle", cli_gnt, 2'b00);
    tick();
    chk("rr_c1_gnt", cli_gnt, 2'b10);
    chk("rr_owner", owner, 1'b1);

    // Burst by client 1: register byte then 128 data bytes.
    cli_req = 2'b10;
    cli_send_en = 2'b00;
    cli_brust_vaild = 2'b11;
    cli_send_addr[1] = OLED_DAT_REG;
    for (int k = 0; k < 129; k++) begin
      b = (k == 0) ? OLED_DAT_REG : 8'(k * 7 + 3);
      cli_send_data[1] = b;
      cli_send_data[0] = ~b;
      m_brust_ready = 1'(k % 2);
      #1;
      chk("burst_data", m_send_data, b);
      chk("burst_rdy", cli_brust_ready, {m_brust_ready, 1'b0});
      tick();
    end
    chk("burst_vld", m_brust_vaild, 1'b1);
    chk("burst_addr", m_send_addr, 8'h40);
    cli_brust_vaild[1] = 1'b0;
    #1;
    chk("burst_vld_off", m_brust_vaild, 1'b0);

    // Hold timeout: client 0 requests while client 1 keeps the bus.
    cli_req = 2'b11;
    for (int i = 0; i < 9; i++) tick();
    chk("hold_pre", err_hold, 1'b0);
    tick();
    chk("hold_pulse", err_hold, 1'b1);
    chk("hold_gnt", cli_gnt, 2'b10);
    tick();
    chk("hold_once", err_hold, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("hold_sat", err_hold, 1'b0);
    chk("hold_keep", cli_gnt, 2'b10);

    // Asynchronous reset mid-transfer.
    cli_send_en = 2'b10;
    m_send_busy = 1'b1;
    #1;
    chk("pre_rst_en", m_send_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", cli_gnt, 2'b00);
    chk("mid_rst_en", m_send_en, 1'b0);
    chk("mid_rst_busy", cli_send_busy, 2'b11);
    chk("mid_rst_owner", owner, 1'b0);
    #10;
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
